// File: rtl/apb_hbridge_pkg.sv
// Shared register map, CTRL bit positions and channel-state layout for the
// APB H-bridge PWM controller.
package apb_hbridge_pkg;

   localparam int unsigned REG_PERIOD = 32'h00;
   localparam int unsigned REG_STATUS = 32'h04;
   localparam int unsigned CH_BASE    = 32'h10;
   localparam int unsigned CH_STRIDE  = 32'h10;
   localparam int unsigned CH_CTRL    = 32'h0;
   localparam int unsigned CH_TARGET  = 32'h4;
   localparam int unsigned CH_STEP    = 32'h8;
   localparam int unsigned CH_CUR     = 32'hC;

   localparam int unsigned CTRL_EN    = 0;
   localparam int unsigned CTRL_DIR   = 1;
   localparam int unsigned CTRL_BRAKE = 2;
   localparam int unsigned CTRL_W     = 3;

   // Widest supported PWM field; per-instance fields use the low PWM_WIDTH bits
   localparam int unsigned PWM_MAX_W  = 24;

   typedef struct packed {
      logic [CTRL_W-1:0]    ctrl;
      logic [PWM_MAX_W-1:0] target;
      logic [PWM_MAX_W-1:0] step;
      logic [PWM_MAX_W-1:0] cur;
      logic                 applied_dir;
      logic                 pending;
   } ch_state_t;

endpackage

// File: rtl/hbridge_channel.sv
// One H-bridge channel: ramp-limited duty, deferred direction reversal,
// PWM compare and registered bridge outputs.
module hbridge_channel
   import apb_hbridge_pkg::*;
#(
   parameter int unsigned PWM_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [PWM_WIDTH-1:0] cnt,
   input  logic                 wrap,
   input  logic [CTRL_W-1:0]    ctrl,
   input  logic [PWM_WIDTH-1:0] target,
   input  logic [PWM_WIDTH-1:0] step,
   output logic [PWM_WIDTH-1:0] cur,
   output logic                 busy,
   output logic                 hb1,
   output logic                 hb2
);

   logic                 applied_dir;
   logic                 pending;
   logic                 pwm;
   logic [PWM_WIDTH-1:0] eff_target;
   logic [PWM_WIDTH-1:0] diff;
   logic [PWM_WIDTH-1:0] delta;
   logic [PWM_WIDTH-1:0] cur_next;

   // The pending flag is exactly "requested dir differs from the applied one"
   assign pending    = ctrl[CTRL_DIR] != applied_dir;
   assign eff_target = (!ctrl[CTRL_EN] || pending) ? '0 : target;
   assign busy       = (cur != eff_target) || pending;
   assign pwm        = cnt < cur;

   // Step toward the effective target by min(step, |diff|); step 0 jumps
   always_comb begin
      diff     = '0;
      delta    = '0;
      cur_next = cur;
      diff     = (cur > eff_target) ? (cur - eff_target) : (eff_target - cur);
      delta    = ((step == '0) || (step > diff)) ? diff : step;
      cur_next = (cur > eff_target) ? (cur - delta) : (cur + delta);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur         <= '0;
         applied_dir <= 1'b0;
         hb1         <= 1'b0;
         hb2         <= 1'b0;
      end else begin
         if (wrap) begin
            cur <= cur_next;
            if (cur_next == '0) applied_dir <= ctrl[CTRL_DIR];
         end
         hb1 <= ctrl[CTRL_BRAKE] | (ctrl[CTRL_EN] & ~pending & ~applied_dir & pwm);
         hb2 <= ctrl[CTRL_BRAKE] | (ctrl[CTRL_EN] & ~pending &  applied_dir & pwm);
      end
   end

endmodule

// File: rtl/apb_hbridge_pwm_ctrl.sv
// APB3 slave driving NUM_CH H-bridge channels: register decode, PERIOD and
// the shared PWM period counter live here; per-channel logic is in hbridge_channel.
module apb_hbridge_pwm_ctrl
   import apb_hbridge_pkg::*;
#(
   parameter int unsigned NUM_CH         = 2,
   parameter int unsigned PWM_WIDTH      = 16,
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned DEFAULT_PERIOD = 1000
) (
   input  logic                  PCLK,
   input  logic                  PRESERN,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]           PWDATA,
   output logic [31:0]           PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR,
   output logic [NUM_CH-1:0]     HB1,
   output logic [NUM_CH-1:0]     HB2
);

   logic [ADDR_WIDTH-1:0] addr_w;
   logic [PWM_WIDTH-1:0]  wdata_f;
   logic [PWM_WIDTH-1:0]  period;
   logic [PWM_WIDTH-1:0]  cnt;
   logic                  wrap;
   logic [CTRL_W-1:0]     ctrl_q   [NUM_CH];
   logic [PWM_WIDTH-1:0]  target_q [NUM_CH];
   logic [PWM_WIDTH-1:0]  step_q   [NUM_CH];
   logic [PWM_WIDTH-1:0]  cur      [NUM_CH];
   logic [NUM_CH-1:0]     busy;
   logic [NUM_CH-1:0]     sel_ctrl, sel_target, sel_step, sel_cur;
   logic                  sel_period, sel_status, mapped, access, err_c, wr_ok;
   logic [31:0]           rd_mux;
   logic                  unused_bits;

   assign addr_w      = {PADDR[ADDR_WIDTH-1:2], 2'b00};
   assign wdata_f     = PWDATA[PWM_WIDTH-1:0];
   assign unused_bits = ^{PWDATA[31:PWM_WIDTH], PADDR[1:0]};

   // Address decode and read mux
   always_comb begin
      sel_period = 1'b0;
      sel_status = 1'b0;
      sel_ctrl   = '0;
      sel_target = '0;
      sel_step   = '0;
      sel_cur    = '0;
      rd_mux     = '0;
      if (addr_w == ADDR_WIDTH'(REG_PERIOD)) begin
         sel_period = 1'b1;
         rd_mux     = 32'(period);
      end
      if (addr_w == ADDR_WIDTH'(REG_STATUS)) begin
         sel_status = 1'b1;
         rd_mux     = 32'(busy);
      end
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (addr_w == ADDR_WIDTH'(CH_BASE + CH_STRIDE * c + CH_CTRL)) begin
            sel_ctrl[c] = 1'b1;
            rd_mux      = 32'(ctrl_q[c]);
         end
         if (addr_w == ADDR_WIDTH'(CH_BASE + CH_STRIDE * c + CH_TARGET)) begin
            sel_target[c] = 1'b1;
            rd_mux        = 32'(target_q[c]);
         end
         if (addr_w == ADDR_WIDTH'(CH_BASE + CH_STRIDE * c + CH_STEP)) begin
            sel_step[c] = 1'b1;
            rd_mux      = 32'(step_q[c]);
         end
         if (addr_w == ADDR_WIDTH'(CH_BASE + CH_STRIDE * c + CH_CUR)) begin
            sel_cur[c] = 1'b1;
            rd_mux     = 32'(cur[c]);
         end
      end
   end

   assign mapped  = sel_period | sel_status | (|sel_ctrl) | (|sel_target) | (|sel_step) | (|sel_cur);
   assign access  = PSEL & PENABLE;
   assign err_c   = access & (~mapped | (PWRITE & (sel_status | (|sel_cur))));
   assign wr_ok   = access & PWRITE & ~err_c;
   assign PSLVERR = err_c;
   assign PREADY  = 1'b1;
   assign PRDATA  = (access && !PWRITE && mapped) ? rd_mux : '0;

   // Counter also wraps when PERIOD is lowered below the current count
   assign wrap = cnt >= (period - PWM_WIDTH'(1));

   always_ff @(posedge PCLK) begin
      if (!PRESERN) begin
         period <= PWM_WIDTH'(DEFAULT_PERIOD);
         cnt    <= '0;
      end else begin
         cnt <= wrap ? '0 : (cnt + PWM_WIDTH'(1));
         if (wr_ok && sel_period) period <= (wdata_f == '0) ? PWM_WIDTH'(1) : wdata_f;
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESERN) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            ctrl_q[c]   <= '0;
            target_q[c] <= '0;
            step_q[c]   <= '0;
         end
      end else if (wr_ok) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (sel_ctrl[c])   ctrl_q[c]   <= PWDATA[CTRL_W-1:0];
            if (sel_target[c]) target_q[c] <= wdata_f;
            if (sel_step[c])   step_q[c]   <= wdata_f;
         end
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      hbridge_channel #(.PWM_WIDTH(PWM_WIDTH)) u_ch (
         .clk    (PCLK),
         .rst_n  (PRESERN),
         .cnt    (cnt),
         .wrap   (wrap),
         .ctrl   (ctrl_q[c]),
         .target (target_q[c]),
         .step   (step_q[c]),
         .cur    (cur[c]),
         .busy   (busy[c]),
         .hb1    (HB1[c]),
         .hb2    (HB2[c])
      );
   end

endmodule

// File: tb/tb_apb_hbridge_pwm_ctrl.sv
// Self-checking bench for apb_hbridge_pwm_ctrl: register table, APB scoreboard,
// and hand-written ramp / reversal / brake / reset sequences on channel 0.
module tb_apb_hbridge_pwm_ctrl;

   localparam int unsigned NUM_CH     = 2;
   localparam int unsigned ADDR_WIDTH = 8;

   logic                  PCLK = 1'b0;
   logic                  PRESERN = 1'b0;
   logic                  PSEL = 1'b0;
   logic                  PENABLE = 1'b0;
   logic                  PWRITE = 1'b0;
   logic [ADDR_WIDTH-1:0] PADDR = '0;
   logic [31:0]           PWDATA = '0;
   logic [31:0]           PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;
   logic [NUM_CH-1:0]     HB1;
   logic [NUM_CH-1:0]     HB2;

   always #5 PCLK = ~PCLK;

   apb_hbridge_pwm_ctrl #(
      .NUM_CH(NUM_CH), .PWM_WIDTH(16), .ADDR_WIDTH(ADDR_WIDTH), .DEFAULT_PERIOD(1000)
   ) dut (
      .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .HB1(HB1), .HB2(HB2)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        chk_rd;
      logic [7:0]  addr;
   } sb_t;

   typedef struct {
      logic [7:0]  addr;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      logic        chk_rd;
   } vec_t;

   sb_t         sb[$];
   sb_t         mon_e;
   vec_t        vecs[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic        allow_overlap = 1'b0;
   int          overlap_cnt = 0;
   logic        count_en = 1'b0;
   int          hb1_cnt = 0;
   int          hb2_cnt = 0;
   logic [31:0] unused_rd;
   int          c1, c2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // APB scoreboard: every access phase pops one expectation
   always @(negedge PCLK) begin
      if (PSEL && PENABLE) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_underflow: access at addr %h with no expectation", PADDR);
         end else begin
            mon_e = sb.pop_front();
            n_checks++;
            if (PSLVERR !== mon_e.err) begin
               n_errors++;
               $display("FAIL pslverr addr=%h: got %0d expected %0d", mon_e.addr, PSLVERR, mon_e.err);
            end
            n_checks++;
            if (PREADY !== 1'b1) begin
               n_errors++;
               $display("FAIL pready addr=%h: got %0d expected 1", mon_e.addr, PREADY);
            end
            if (mon_e.chk_rd) begin
               n_checks++;
               if (PRDATA !== mon_e.rdata) begin
                  n_errors++;
                  $display("FAIL prdata addr=%h: got %0d expected %0d", mon_e.addr, PRDATA, mon_e.rdata);
               end
            end
         end
      end
   end

   always @(negedge PCLK) begin
      if (PRESERN && !allow_overlap && ((HB1 & HB2) != '0)) overlap_cnt++;
      if (count_en) begin
         hb1_cnt += int'(HB1[0]);
         hb2_cnt += int'(HB2[0]);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic xfer(input logic [7:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input logic chk_rd,
                       output logic [31:0] rdata);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
      sb.push_back('{exp_rd, exp_err, chk_rd, addr});
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      rdata = PRDATA;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] data);
      logic [31:0] d;
      xfer(addr, 1'b1, data, 32'd0, 1'b0, 1'b0, d);
   endtask

   task automatic rd(input logic [7:0] addr, output logic [31:0] data);
      xfer(addr, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, data);
   endtask

   task automatic rd_chk(input logic [7:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      xfer(addr, 1'b0, 32'd0, exp, 1'b0, 1'b1, d);
   endtask

   task automatic count_hb(input int n, output int h1, output int h2);
      h1 = 0;
      h2 = 0;
      repeat (n) begin
         @(negedge PCLK);
         h1 += int'(HB1[0]);
         h2 += int'(HB2[0]);
      end
   endtask

   // Poll ch0 CUR until it reaches stop; each new value must be one step on,
   // and STATUS[0] must read busy until stop, then stop_busy
   task automatic poll_cur(input int start, input int stop, input logic stop_busy);
      int          prev;
      int          dirn;
      bit          done;
      logic [31:0] r;
      prev = start;
      dirn = (stop > start) ? 1 : -1;
      done = (start == stop);
      for (int i = 0; i < 300 && !done; i++) begin
         rd(8'h1C, r);
         if (int'(r) != prev) begin
            check("cur_ramp_step", r, 32'(prev + dirn));
            rd_chk(8'h04, (int'(r) == stop) ? 32'(stop_busy) : 32'd1);
            prev = int'(r);
            if (prev == stop) done = 1'b1;
         end
      end
      if (!done) check("cur_ramp_timeout", 32'(prev), 32'(stop));
   endtask

   initial begin
      // Reset-state register table, error responses and address aliasing
      vecs.push_back('{8'h00, 1'b0, 32'd0,       32'd1000,   1'b0, 1'b1});
      vecs.push_back('{8'h04, 1'b0, 32'd0,       32'd0,      1'b0, 1'b1});
      vecs.push_back('{8'h10, 1'b0, 32'd0,       32'd0,      1'b0, 1'b1});
      vecs.push_back('{8'h14, 1'b0, 32'd0,       32'd0,      1'b0, 1'b1});
      vecs.push_back('{8'h18, 1'b0, 32'd0,       32'd0,      1'b0, 1'b1});
      vecs.push_back('{8'h1C, 1'b0, 32'd0,       32'd0,      1'b0, 1'b1});
      vecs.push_back('{8'h20, 1'b0, 32'd0,       32'd0,      1'b0, 1'b1});
      vecs.push_back('{8'h24, 1'b0, 32'd0,       32'd0,      1'b0, 1'b1});
      vecs.push_back('{8'h28, 1'b0, 32'd0,       32'd0,      1'b0, 1'b1});
      vecs.push_back('{8'h2C, 1'b0, 32'd0,       32'd0,      1'b0, 1'b1});
      vecs.push_back('{8'h08, 1'b0, 32'd0,       32'd0,      1'b1, 1'b1});
      vecs.push_back('{8'h0C, 1'b0, 32'd0,       32'd0,      1'b1, 1'b1});
      vecs.push_back('{8'h30, 1'b0, 32'd0,       32'd0,      1'b1, 1'b1});
      vecs.push_back('{8'h40, 1'b0, 32'd0,       32'd0,      1'b1, 1'b1});
      vecs.push_back('{8'h04, 1'b1, 32'd3,       32'd0,      1'b1, 1'b0});
      vecs.push_back('{8'h1C, 1'b1, 32'd7,       32'd0,      1'b1, 1'b0});
      vecs.push_back('{8'h34, 1'b1, 32'd5,       32'd0,      1'b1, 1'b0});
      vecs.push_back('{8'h04, 1'b0, 32'd0,       32'd0,      1'b0, 1'b1});
      vecs.push_back('{8'h1C, 1'b0, 32'd0,       32'd0,      1'b0, 1'b1});
      vecs.push_back('{8'h26, 1'b1, 32'h12345,   32'd0,      1'b0, 1'b0});
      vecs.push_back('{8'h24, 1'b0, 32'd0,       32'h2345,   1'b0, 1'b1});
      vecs.push_back('{8'h24, 1'b1, 32'd0,       32'd0,      1'b0, 1'b0});
      vecs.push_back('{8'h00, 1'b0, 32'd0,       32'd1000,   1'b0, 1'b1});

      repeat (3) @(posedge PCLK);
      #1 PRESERN = 1'b1;
      @(negedge PCLK);
      check("reset_hb1", 32'(HB1), 32'd0);
      check("reset_hb2", 32'(HB2), 32'd0);
      check("idle_prdata", PRDATA, 32'd0);
      check("idle_pslverr", 32'(PSLVERR), 32'd0);

      foreach (vecs[i])
         xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].rdata, vecs[i].err,
              vecs[i].chk_rd, unused_rd);

      // Fixed duty, step 0: 4 of every 10 cycles high on HB1
      wr(8'h00, 32'd10);
      wr(8'h14, 32'd4);
      wr(8'h18, 32'd0);
      wr(8'h10, 32'h1);
      repeat (25) @(posedge PCLK);
      count_hb(10, c1, c2);
      check("duty4_hb1", 32'(c1), 32'd4);
      check("duty4_hb2", 32'(c2), 32'd0);
      rd_chk(8'h1C, 32'd4);
      rd_chk(8'h04, 32'd0);

      // Ramp 0 -> 5 with step 1
      wr(8'h14, 32'd0);
      repeat (15) @(posedge PCLK);
      rd_chk(8'h1C, 32'd0);
      wr(8'h00, 32'd50);
      wr(8'h18, 32'd1);
      wr(8'h14, 32'd5);
      poll_cur(0, 5, 1'b0);

      // Brake overrides PWM; CUR keeps ramping, step larger than gap saturates
      allow_overlap = 1'b1;
      wr(8'h10, 32'h5);
      @(posedge PCLK);
      count_hb(20, c1, c2);
      check("brake_hb1", 32'(c1), 32'd20);
      check("brake_hb2", 32'(c2), 32'd20);
      wr(8'h18, 32'd100);
      wr(8'h14, 32'd3);
      repeat (110) @(posedge PCLK);
      rd_chk(8'h1C, 32'd3);
      wr(8'h18, 32'd1);
      wr(8'h10, 32'h1);
      @(posedge PCLK);
      #1 allow_overlap = 1'b0;
      count_hb(50, c1, c2);
      check("post_brake_hb1", 32'(c1), 32'd3);
      check("post_brake_hb2", 32'(c2), 32'd0);

      // Direction reversal: ramp down to 0 with outputs off, flip, ramp back up
      wr(8'h10, 32'h3);
      @(posedge PCLK);
      hb1_cnt = 0;
      hb2_cnt = 0;
      count_en = 1'b1;
      rd_chk(8'h04, 32'd1);
      poll_cur(3, 0, 1'b1);
      count_en = 1'b0;
      check("pending_hb1_off", 32'(hb1_cnt), 32'd0);
      check("pending_hb2_off", 32'(hb2_cnt), 32'd0);
      hb1_cnt = 0;
      hb2_cnt = 0;
      count_en = 1'b1;
      poll_cur(0, 3, 1'b0);
      count_en = 1'b0;
      check("rev_rampup_hb1", 32'(hb1_cnt), 32'd0);
      check("rev_rampup_hb2_pulses", 32'(hb2_cnt > 0), 32'd1);
      count_hb(50, c1, c2);
      check("rev_hb1", 32'(c1), 32'd0);
      check("rev_hb2", 32'(c2), 32'd3);

      // CUR is read-only; PERIOD 0 stores 1 giving 100% duty
      xfer(8'h1C, 1'b1, 32'd99, 32'd0, 1'b1, 1'b0, unused_rd);
      rd_chk(8'h1C, 32'd3);
      wr(8'h00, 32'd0);
      rd_chk(8'h00, 32'd1);
      repeat (5) @(posedge PCLK);
      count_hb(10, c1, c2);
      check("period1_hb1", 32'(c1), 32'd0);
      check("period1_hb2", 32'(c2), 32'd10);

      // One-cycle reset pulse while running
      @(posedge PCLK); #1 PRESERN = 1'b0;
      @(posedge PCLK); #1 PRESERN = 1'b1;
      @(negedge PCLK);
      check("rst_pulse_hb1", 32'(HB1), 32'd0);
      check("rst_pulse_hb2", 32'(HB2), 32'd0);
      rd_chk(8'h00, 32'd1000);
      rd_chk(8'h10, 32'd0);
      rd_chk(8'h1C, 32'd0);
      rd_chk(8'h04, 32'd0);

      check("hb_overlap", 32'(overlap_cnt), 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
